// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8-bit ALU slice.
//   WIDTH            data-path width
//   OP_ADD..OP_SHR   3-bit opcode encodings
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between a requester and the ALU.
//   A, B, opcode, in_valid              request side (driven by master)
//   Result, Zero, Carry, Negative,
//   Overflow, out_valid                 response side (driven by slave)
interface alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             in_valid;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Carry;
    logic             Negative;
    logic             Overflow;
    logic             out_valid;

    modport master (
        output A, B, opcode, in_valid,
        input  Result, Zero, Carry, Negative, Overflow, out_valid
    );

    modport slave (
        input  A, B, opcode, in_valid,
        output Result, Zero, Carry, Negative, Overflow, out_valid
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational datapath.
//   a, b      operands
//   opcode    operation select
//   result    8-bit truncated result
//   carry     carry-out / borrow / shifted-out bit, 0 for logic ops
//   overflow  signed overflow for ADD/SUB, 0 otherwise
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide     = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[WIDTH-1:0];
                carry    = wide[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The 9th bit of a zero-extended subtraction is the borrow (a < b).
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[WIDTH-1:0];
                carry    = wide[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU with one-cycle latency.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, overrides in_valid
//   bus   alu_if slave: A/B/opcode/in_valid in, Result/flags/out_valid out
// Result and flags update only on an accepted operation and hold otherwise;
// out_valid pulses for exactly the cycle after each accepted operation.
module alu_8bit
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_overflow;

    alu_core u_core (
        .a        (bus.A),
        .b        (bus.B),
        .opcode   (bus.opcode),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Result    <= '0;
            bus.Zero      <= 1'b1;
            bus.Carry     <= 1'b0;
            bus.Negative  <= 1'b0;
            bus.Overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.Result    <= core_result;
            bus.Zero      <= (core_result == '0);
            bus.Carry     <= core_carry;
            bus.Negative  <= core_result[WIDTH-1];
            bus.Overflow  <= core_overflow;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_if u_if ();

    alu_8bit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // expected output state
    logic [7:0] exp_res;
    logic       exp_z, exp_c, exp_n, exp_v, exp_ov;

    function automatic int sgn(input logic [7:0] x);
        return (x > 8'd127) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  output logic [7:0] r, output logic c, output logic v);
        int s;
        int ss;
        s = 0; ss = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s  = int'(a) + int'(b);
                r  = 8'(s % 256);
                c  = (s > 255);
                ss = sgn(a) + sgn(b);
                v  = (ss > 127) || (ss < -128);
            end
            3'd1: begin
                s  = int'(a) - int'(b);
                r  = 8'((s + 256) % 256);
                c  = (a < b);
                ss = sgn(a) - sgn(b);
                v  = (ss > 127) || (ss < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 8'(255 - int'(a));
            3'd6: begin
                r = 8'((int'(a) * 2) % 256);
                c = (a >= 8'd128);
            end
            default: begin
                r = 8'(int'(a) / 2);
                c = (int'(a) % 2) == 1;
            end
        endcase
    endfunction

    // reference model: advances on every rising edge from the applied inputs
    always @(posedge clk) begin
        logic [7:0] r;
        logic c, v;
        if (rst) begin
            exp_res = 8'd0; exp_z = 1'b1; exp_c = 1'b0; exp_n = 1'b0; exp_v = 1'b0; exp_ov = 1'b0;
        end else if (u_if.in_valid) begin
            model(u_if.A, u_if.B, u_if.opcode, r, c, v);
            exp_res = r;
            exp_z   = (r == 8'd0);
            exp_n   = (r >= 8'd128);
            exp_c   = c;
            exp_v   = v;
            exp_ov  = 1'b1;
        end else begin
            exp_ov  = 1'b0;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (u_if.Result !== exp_res) begin
                miscompares++;
                $display("FAIL result: got %0d expected %0d at %0t", u_if.Result, exp_res, $time);
            end
            if (u_if.Zero !== exp_z) begin
                miscompares++;
                $display("FAIL zero: got %b expected %b at %0t", u_if.Zero, exp_z, $time);
            end
            if (u_if.Carry !== exp_c) begin
                miscompares++;
                $display("FAIL carry: got %b expected %b at %0t", u_if.Carry, exp_c, $time);
            end
            if (u_if.Negative !== exp_n) begin
                miscompares++;
                $display("FAIL negative: got %b expected %b at %0t", u_if.Negative, exp_n, $time);
            end
            if (u_if.Overflow !== exp_v) begin
                miscompares++;
                $display("FAIL overflow: got %b expected %b at %0t", u_if.Overflow, exp_v, $time);
            end
            if (u_if.out_valid !== exp_ov) begin
                miscompares++;
                $display("FAIL out_valid: got %b expected %b at %0t", u_if.out_valid, exp_ov, $time);
            end
        end
    end

    task automatic apply(input logic r, input logic iv, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
        @(negedge clk);
        rst           = r;
        u_if.in_valid = iv;
        u_if.A        = a;
        u_if.B        = b;
        u_if.opcode   = op;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.A = 8'd0;
        u_if.B = 8'd0;
        u_if.opcode = 3'd0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        apply(1'b1, 1'b0, 8'd0, 8'd0, 3'd0);
        lit("reset_result", u_if.Result, 8'd0);
        lit("reset_zero", 8'(u_if.Zero), 8'd1);
        lit("reset_carry", 8'(u_if.Carry), 8'd0);
        lit("reset_out_valid", 8'(u_if.out_valid), 8'd0);

        apply(1'b0, 1'b1, 8'd5, 8'd3, OP_ADD);
        lit("add_result", u_if.Result, 8'd8);
        lit("add_zero", 8'(u_if.Zero), 8'd0);
        lit("add_carry", 8'(u_if.Carry), 8'd0);
        lit("add_out_valid", 8'(u_if.out_valid), 8'd1);

        apply(1'b0, 1'b0, 8'd77, 8'd99, OP_SUB);
        lit("hold_result", u_if.Result, 8'd8);
        lit("hold_out_valid", 8'(u_if.out_valid), 8'd0);

        apply(1'b0, 1'b1, 8'd5, 8'd5, OP_SUB);
        lit("sub_eq_result", u_if.Result, 8'd0);
        lit("sub_eq_zero", 8'(u_if.Zero), 8'd1);
        lit("sub_eq_carry", 8'(u_if.Carry), 8'd0);

        apply(1'b0, 1'b1, 8'd0, 8'd1, OP_SUB);
        lit("sub_wrap_result", u_if.Result, 8'd255);
        lit("sub_wrap_carry", 8'(u_if.Carry), 8'd1);
        lit("sub_wrap_negative", 8'(u_if.Negative), 8'd1);

        apply(1'b0, 1'b1, 8'b10101010, 8'b11001100, OP_AND);
        lit("and_result", u_if.Result, 8'b10001000);
        lit("and_zero", 8'(u_if.Zero), 8'd0);
        lit("and_carry", 8'(u_if.Carry), 8'd0);

        apply(1'b0, 1'b1, 8'd127, 8'd1, OP_ADD);
        lit("add_ovf_result", u_if.Result, 8'd128);
        lit("add_ovf_overflow", 8'(u_if.Overflow), 8'd1);
        lit("add_ovf_negative", 8'(u_if.Negative), 8'd1);

        apply(1'b0, 1'b1, 8'd255, 8'd1, OP_ADD);
        lit("add_wrap_result", u_if.Result, 8'd0);
        lit("add_wrap_carry", 8'(u_if.Carry), 8'd1);
        lit("add_wrap_zero", 8'(u_if.Zero), 8'd1);

        apply(1'b0, 1'b1, 8'h81, 8'h00, OP_SHL);
        lit("shl_result", u_if.Result, 8'h02);
        lit("shl_carry", 8'(u_if.Carry), 8'd1);

        apply(1'b0, 1'b1, 8'h81, 8'h00, OP_SHR);
        lit("shr_result", u_if.Result, 8'h40);
        lit("shr_carry", 8'(u_if.Carry), 8'd1);

        apply(1'b1, 1'b1, 8'd5, 8'd3, OP_ADD);
        lit("rst_prio_result", u_if.Result, 8'd0);
        lit("rst_prio_zero", 8'(u_if.Zero), 8'd1);
        lit("rst_prio_out_valid", 8'(u_if.out_valid), 8'd0);

        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 3'($urandom));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
